// File: rtl/lanectrl_pause_gen_if.sv
// Request/handshake bundle between a tap-move requester and the pause sequencer.
// Also carries the pause and delay-cell strobes the sequencer drives outward.
interface lanectrl_pause_gen_if;
  logic       update_req;
  logic       update_dir;
  logic [7:0] update_steps;
  logic       update_ack;
  logic       busy;
  logic       hs_io_clk_pause;
  logic       delay_move;
  logic       delay_dir;

  modport master (
    output update_req,
    output update_dir,
    output update_steps,
    input  update_ack,
    input  busy,
    input  hs_io_clk_pause,
    input  delay_move,
    input  delay_dir
  );

  modport slave (
    input  update_req,
    input  update_dir,
    input  update_steps,
    output update_ack,
    output busy,
    output hs_io_clk_pause,
    output delay_move,
    output delay_dir
  );
endinterface

// File: rtl/lanectrl_pause_gen.sv
// Delay-update sequencer: holds HS_IO_CLK_PAUSE around a burst of spaced DELAY_MOVE strobes,
// then acknowledges the requester and enforces a pause-low guard interval.
module lanectrl_pause_gen #(
  parameter int unsigned PrePauseCycles  = 2,
  parameter int unsigned PostPauseCycles = 2,
  parameter int unsigned GuardCycles     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lanectrl_pause_gen_if.slave  upd_io
);

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StMove,
    StSpace,
    StPost,
    StGuard
  } state_e;

  localparam logic [3:0] PreCnt   = 4'(PrePauseCycles);
  localparam logic [3:0] PostCnt  = 4'(PostPauseCycles);
  localparam logic [3:0] GuardCnt = 4'(GuardCycles);

  state_e     state_q, state_d;
  logic [7:0] steps_q, steps_d;
  logic [3:0] phase_q, phase_d;
  logic       dir_q, dir_d;
  logic       pause_q, pause_d;
  logic       move_q, move_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (upd_io.update_req) begin
          steps_d = upd_io.update_steps;
          dir_d   = upd_io.update_dir;
          phase_d = PreCnt;
          state_d = StPre;
        end
      end
      StPre: begin
        if (phase_q <= 4'd1) begin
          if (steps_q != 8'd0) begin
            state_d = StMove;
          end else begin
            state_d = StPost;
            phase_d = PostCnt;
          end
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      StMove: begin
        steps_d = steps_q - 8'd1;
        state_d = StSpace;
      end
      StSpace: begin
        if (steps_q != 8'd0) begin
          state_d = StMove;
        end else begin
          state_d = StPost;
          phase_d = PostCnt;
        end
      end
      StPost: begin
        // Phase 0 is the ACK cycle: pause already low, busy still high.
        if (phase_q != 4'd0) begin
          phase_d = phase_q - 4'd1;
        end else if (GuardCnt != 4'd0) begin
          state_d = StGuard;
          phase_d = GuardCnt;
        end else begin
          state_d = StIdle;
        end
      end
      StGuard: begin
        if (phase_q <= 4'd1) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every output is a plain flop.
  always_comb begin
    move_d  = (state_d == StMove);
    ack_d   = (state_d == StPost) && (phase_d == 4'd0);
    busy_d  = (state_d != StIdle);
    pause_d = busy_d && (state_d != StGuard) && !ack_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      steps_q <= 8'd0;
      phase_q <= 4'd0;
      dir_q   <= 1'b0;
      pause_q <= 1'b0;
      move_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      pause_q <= pause_d;
      move_q  <= move_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign upd_io.update_ack      = ack_q;
  assign upd_io.busy            = busy_q;
  assign upd_io.hs_io_clk_pause = pause_q;
  assign upd_io.delay_move      = move_q;
  assign upd_io.delay_dir       = dir_q;

endmodule

// File: tb/tb_lanectrl_pause_gen.sv
// Bench for lanectrl_pause_gen: directed and random transactions compared cycle by cycle
// against a timeline model built from the pause/strobe/ack/guard timing rules.
module tb_lanectrl_pause_gen;
  localparam int Pre   = 2;
  localparam int Post  = 2;
  localparam int Guard = 4;

  logic clk = 1'b0;
  logic rst;

  lanectrl_pause_gen_if bus ();

  lanectrl_pause_gen #(
    .PrePauseCycles (Pre),
    .PostPauseCycles(Post),
    .GuardCycles    (Guard)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .upd_io(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a transaction is a timeline indexed by cycles since capture.
  bit   m_act = 1'b0;
  int   m_t   = 0;
  int   m_n   = 0;
  logic m_dir = 1'b0;

  // Observed-waveform statistics.
  bit prev_pause = 1'b0;
  int pause_run  = 0;
  int low_run    = 0;
  int last_width = 0;
  int last_gap   = 0;
  int moves      = 0;
  int acks       = 0;

  function automatic int plen(input int n);
    return Pre + 2 * n + Post;
  endfunction

  function automatic logic exp_pause();
    return m_act && (m_t < plen(m_n));
  endfunction

  function automatic logic exp_move();
    return m_act && (m_t >= Pre) && (m_t < Pre + 2 * m_n) && (((m_t - Pre) % 2) == 0);
  endfunction

  function automatic logic exp_ack();
    return m_act && (m_t == plen(m_n));
  endfunction

  function automatic logic exp_busy();
    return m_act && (m_t <= plen(m_n) + Guard);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_act = 1'b0;
      m_dir = 1'b0;
    end else if (!m_act) begin
      if (bus.update_req) begin
        m_act = 1'b1;
        m_t   = 0;
        m_n   = int'(bus.update_steps);
        m_dir = bus.update_dir;
      end
    end else begin
      m_t++;
      if (m_t > plen(m_n) + Guard) m_act = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, want);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int want);
    checks++;
    assert (obs == want) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, want);
    end
  endtask

  task automatic check_all();
    check("pause", bus.hs_io_clk_pause, exp_pause());
    check("move",  bus.delay_move,      exp_move());
    check("ack",   bus.update_ack,      exp_ack());
    check("busy",  bus.busy,            exp_busy());
    check("dir",   bus.delay_dir,       m_dir);
  endtask

  task automatic stats();
    if (bus.hs_io_clk_pause === 1'b1) begin
      if (!prev_pause) begin
        last_gap  = low_run;
        pause_run = 0;
      end
      pause_run++;
      prev_pause = 1'b1;
    end else begin
      if (prev_pause) begin
        last_width = pause_run;
        low_run    = 0;
      end
      low_run++;
      prev_pause = 1'b0;
    end
    if (bus.delay_move === 1'b1) moves++;
    if (bus.update_ack === 1'b1) acks++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    stats();
    check_all();
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.busy === 1'b0) done = 1'b1;
      else cycle();
    end
    check_int({tag, "_idle"}, int'(done), 1);
  endtask

  // One requester transaction; inputs are scrambled while BUSY to show they are ignored.
  task automatic do_txn(input int n, input logic d, input bit hold, input string tag);
    int moves0;
    int acks0;
    bit got;
    moves0 = moves;
    acks0  = acks;
    got    = 1'b0;
    bus.update_steps = 8'(n);
    bus.update_dir   = d;
    bus.update_req   = 1'b1;
    for (int i = 0; i < 600 && !got; i++) begin
      cycle();
      if (bus.update_ack === 1'b1) got = 1'b1;
      else if (bus.busy === 1'b1) begin
        bus.update_dir   = 1'($urandom);
        bus.update_steps = 8'($urandom);
      end
    end
    check_int({tag, "_ack_seen"}, int'(got), 1);
    if (hold) begin
      bus.update_dir   = 1'($urandom);
      bus.update_steps = 8'($urandom_range(0, 8));
    end else begin
      bus.update_req = 1'b0;
    end
    check_int({tag, "_width"}, last_width, plen(n));
    check_int({tag, "_moves"}, moves - moves0, n);
    check_int({tag, "_acks"},  acks - acks0, 1);
    wait_idle(tag);
  endtask

  initial begin
    int moves0;
    int acks0;
    bit got;

    rst              = 1'b1;
    bus.update_req   = 1'b0;
    bus.update_dir   = 1'b0;
    bus.update_steps = 8'd0;

    // Reset held with random inputs: everything stays low.
    for (int i = 0; i < 4; i++) begin
      bus.update_req   = 1'($urandom);
      bus.update_dir   = 1'($urandom);
      bus.update_steps = 8'($urandom);
      cycle();
    end
    bus.update_req = 1'b0;
    rst = 1'b0;
    repeat (3) cycle();

    do_txn(1, 1'b1, 1'b0, "single");
    do_txn(0, 1'b0, 1'b0, "zero");
    do_txn(255, 1'($urandom), 1'b0, "max");

    // Back-to-back: request held across ACK.
    do_txn(2, 1'b0, 1'b1, "b2b_a");
    do_txn(3, 1'b1, 1'b0, "b2b_b");
    check_int("b2b_gap", last_gap, Guard + 2);

    // Reset asynchronously at the 3rd strobe of a 10-step move.
    moves0 = moves;
    got    = 1'b0;
    bus.update_steps = 8'd10;
    bus.update_dir   = 1'b1;
    bus.update_req   = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      cycle();
      if (bus.delay_move === 1'b1 && (moves - moves0) == 3) got = 1'b1;
    end
    check_int("rstmv_third_move", int'(got), 1);
    #2 rst = 1'b1;
    #1;
    check("rstmv_pause", bus.hs_io_clk_pause, 1'b0);
    check("rstmv_move",  bus.delay_move,      1'b0);
    check("rstmv_ack",   bus.update_ack,      1'b0);
    check("rstmv_busy",  bus.busy,            1'b0);
    check("rstmv_dir",   bus.delay_dir,       1'b0);
    m_act = 1'b0;
    m_dir = 1'b0;
    acks0 = acks;
    bus.update_req = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (3) cycle();
    check_int("rstmv_no_ack", acks - acks0, 0);
    do_txn(1, 1'b1, 1'b0, "post_rst");

    // Random traffic with occasional held requests.
    for (int k = 0; k < 15; k++) begin
      bit hold;
      hold = (k < 14) && ($urandom_range(0, 3) == 0);
      do_txn(int'($urandom_range(0, 8)), 1'($urandom), hold, "rnd");
      if (!hold) repeat ($urandom_range(0, 3)) cycle();
    end
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
